fifo_sync_mc: RTL

Multi-channel synchronous FIFO: NUM_CH independent FIFOs of WIDTH x DEPTH behind one shared write port and one shared read port, each selected by a channel index. It buffers per-virtual-channel flit traffic in the adapter datapath. It adds these features:
- per-channel synchronous flush
- almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a registered credit-return pulse per dequeued entry, for credit-based flow control toward the link partner

---
 rtl/fifo_sync_mc.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_mc.sv
// fifo_sync_mc
// NUM_CH independent WIDTH x DEPTH FIFOs behind one shared write port and one
// shared read port, each addressed by a channel index. Used to buffer
// per-virtual-channel flit traffic in the adapter datapath.
//
// Ports
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   clear_i    per-channel synchronous flush (drops contents, errors, credit)
//   push_i     write request to channel wr_ch_i with data wdata_i
//   pop_i      read request to channel rd_ch_i
//   rdata_o    show-ahead head entry of channel rd_ch_i (don't-care if !rvalid_o)
//   rvalid_o   channel rd_ch_i is non-empty
//   full_o / empty_o / afull_o / aempty_o   per-channel status from registered count
//   level_o    flat per-channel occupancy, channel c at [c*LVL_W +: LVL_W]
//   credit_o   one-cycle pulse the cycle after each accepted pop
//   ovf_o / udf_o   sticky rejected-push / rejected-pop flags
//
// Channel indices >= NUM_CH never match any channel, so such requests are
// silently ignored.

module fifo_sync_mc #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int NUM_CH    = 4,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_CH-1:0]       clear_i,
    input  logic                    push_i,
    input  logic [CH_W-1:0]         wr_ch_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    input  logic [CH_W-1:0]         rd_ch_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    rvalid_o,
    output logic [NUM_CH-1:0]       full_o,
    output logic [NUM_CH-1:0]       empty_o,
    output logic [NUM_CH-1:0]       afull_o,
    output logic [NUM_CH-1:0]       aempty_o,
    output logic [NUM_CH*LVL_W-1:0] level_o,
    output logic [NUM_CH-1:0]       credit_o,
    output logic [NUM_CH-1:0]       ovf_o,
    output logic [NUM_CH-1:0]       udf_o
);

    logic [WIDTH-1:0] mem [NUM_CH][DEPTH];

    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [LVL_W-1:0] count_q  [NUM_CH];

    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] rd_hit;
    logic [NUM_CH-1:0] push_acc;
    logic [NUM_CH-1:0] pop_acc;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] udf_set;
    logic [NUM_CH-1:0] credit_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] udf_q;

    // DEPTH need not be a power of two, so wrap by explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Acceptance. A pop needs a non-empty channel; a push to a full channel
    // is still accepted when the same channel is popped in the same cycle.
    always_comb begin
        wr_hit   = '0;
        rd_hit   = '0;
        push_acc = '0;
        pop_acc  = '0;
        ovf_set  = '0;
        udf_set  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit[c]   = push_i && (wr_ch_i == CH_W'(c));
            rd_hit[c]   = pop_i && (rd_ch_i == CH_W'(c));
            pop_acc[c]  = rd_hit[c] && !clear_i[c] && (count_q[c] != '0);
            push_acc[c] = wr_hit[c] && !clear_i[c] &&
                          ((count_q[c] != LVL_W'(DEPTH)) || pop_acc[c]);
            ovf_set[c]  = wr_hit[c] && !clear_i[c] && !push_acc[c];
            udf_set[c]  = rd_hit[c] && !clear_i[c] && !pop_acc[c];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            ovf_q    <= '0;
            udf_q    <= '0;
            credit_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear_i[c]) begin
                    wr_ptr_q[c] <= '0;
                    rd_ptr_q[c] <= '0;
                    count_q[c]  <= '0;
                    ovf_q[c]    <= 1'b0;
                    udf_q[c]    <= 1'b0;
                end else begin
                    if (push_acc[c]) wr_ptr_q[c] <= ptr_inc(wr_ptr_q[c]);
                    if (pop_acc[c])  rd_ptr_q[c] <= ptr_inc(rd_ptr_q[c]);
                    if (push_acc[c] && !pop_acc[c]) begin
                        count_q[c] <= count_q[c] + LVL_W'(1);
                    end else if (pop_acc[c] && !push_acc[c]) begin
                        count_q[c] <= count_q[c] - LVL_W'(1);
                    end
                    if (ovf_set[c]) ovf_q[c] <= 1'b1;
                    if (udf_set[c]) udf_q[c] <= 1'b1;
                end
            end
            // pop_acc is already masked by clear, so a flush never yields credit.
            credit_q <= pop_acc;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push_acc[c]) mem[c][wr_ptr_q[c]] <= wdata_i;
        end
    end

    always_comb begin
        full_o   = '0;
        empty_o  = '0;
        afull_o  = '0;
        aempty_o = '0;
        level_o  = '0;
        rdata_o  = '0;
        rvalid_o = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            full_o[c]   = (count_q[c] == LVL_W'(DEPTH));
            empty_o[c]  = (count_q[c] == '0);
            afull_o[c]  = (int'(count_q[c]) >= AF_THRESH);
            aempty_o[c] = (int'(count_q[c]) <= AE_THRESH);
            level_o[c*LVL_W +: LVL_W] = count_q[c];
            if (rd_ch_i == CH_W'(c)) begin
                rdata_o  = mem[c][rd_ptr_q[c]];
                rvalid_o = (count_q[c] != '0);
            end
        end
    end

    assign credit_o = credit_q;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule
